// File: rtl/count_checker_pkg.sv
// Shared types for the count checker: FSM states, error record layout, count width.
// COUNT_CHECKER_TIMESTAMP_EN adds a 32-bit cycle stamp to every error record.
package count_checker_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_LOCKED,
    ST_FAULT
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] expected;
    logic [CNT_W-1:0] actual;
`ifdef COUNT_CHECKER_TIMESTAMP_EN
    logic [31:0]      ts;
`endif
  } err_rec_t;

  localparam int unsigned REC_W = $bits(err_rec_t);

  function automatic logic [CNT_W-1:0] succ(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/count_checker_fifo.sv
// Error-record FIFO with an extra pointer bit for full/empty; a push into a full
// FIFO is kept only if the head leaves on the same edge, otherwise it is dropped.
module count_checker_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic         ovf
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         r_ovf;
  logic         w_do_pop;
  logic         w_do_push;

  always_comb begin
    valid     = (r_wr_ptr != r_rd_ptr);
    full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_do_pop  = pop && valid;
    w_do_push = push && (!full || w_do_pop);
    head      = valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
    ovf       = r_ovf;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      if (push && !w_do_push) r_ovf <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define contents.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/count_checker.sv
// Checks that an upstream free-running count increments by one each cycle,
// keeps saturating statistics and queues mismatch records.
// COUNT_CHECKER_TIMESTAMP_EN adds the err_time output and per-record cycle stamp.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  count,
  input  logic              check_en,
  output logic              locked,
  output logic [STAT_W-1:0] wrap_cnt,
  output logic [STAT_W-1:0] err_cnt,
  output logic              err_valid,
  input  logic              err_ready,
  output logic [CNT_W-1:0]  err_expected,
  output logic [CNT_W-1:0]  err_actual,
`ifdef COUNT_CHECKER_TIMESTAMP_EN
  output logic [31:0]       err_time,
`endif
  output logic              err_ovf
);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_prev;
  logic [STAT_W-1:0] r_wrap_cnt;
  logic [STAT_W-1:0] r_err_cnt;
  logic              w_match;
  logic              w_push;
  logic              w_wrap;
  logic              w_full;
  err_rec_t          w_rec;
  err_rec_t          w_head;
`ifdef COUNT_CHECKER_TIMESTAMP_EN
  logic [31:0]       r_cycle;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!check_en) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_next = ST_ARMED;
        ST_ARMED:  w_next = w_match ? ST_LOCKED : ST_ARMED;
        ST_LOCKED: w_next = w_match ? ST_LOCKED : ST_FAULT;
        ST_FAULT:  w_next = ST_ARMED;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    locked  = (r_state == ST_LOCKED);
    w_match = (count == succ(r_prev));
    w_push  = check_en && (r_state == ST_LOCKED) && !w_match;
    w_wrap  = check_en && (r_state == ST_LOCKED) && (r_prev == '1) && (count == '0);
  end

  // Every enabled state resamples prev, so one condition covers the whole FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev     <= '0;
      r_wrap_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (check_en) r_prev <= count;
      if (w_wrap && (r_wrap_cnt != '1)) r_wrap_cnt <= r_wrap_cnt + STAT_W'(1);
      if (w_push && (r_err_cnt != '1))  r_err_cnt  <= r_err_cnt + STAT_W'(1);
    end
  end

`ifdef COUNT_CHECKER_TIMESTAMP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cycle <= '0;
    else        r_cycle <= r_cycle + 32'd1;
  end
`endif

  always_comb begin
    w_rec.expected = succ(r_prev);
    w_rec.actual   = count;
`ifdef COUNT_CHECKER_TIMESTAMP_EN
    w_rec.ts       = r_cycle;
`endif
  end

  count_checker_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_rec),
    .full      (w_full),
    .pop       (err_ready),
    .valid     (err_valid),
    .head      (w_head),
    .ovf       (err_ovf)
  );

  assign wrap_cnt     = r_wrap_cnt;
  assign err_cnt      = r_err_cnt;
  assign err_expected = w_head.expected;
  assign err_actual   = w_head.actual;
`ifdef COUNT_CHECKER_TIMESTAMP_EN
  assign err_time     = w_head.ts;
`endif

endmodule

// File: tb/tb_count_checker.sv
// Self-checking bench for count_checker: directed vector table, hand sequences
// and randomized traffic against a queue-based reference model.
module tb_count_checker;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  count;
  logic        check_en;
  logic        err_ready;
  logic        locked, locked2;
  logic [15:0] wrap_cnt, err_cnt;
  logic [1:0]  wrap_cnt2, err_cnt2;
  logic        err_valid, err_valid2;
  logic [7:0]  err_expected, err_actual, err_expected2, err_actual2;
  logic        err_ovf, err_ovf2;
`ifdef COUNT_CHECKER_TIMESTAMP_EN
  logic [31:0] err_time, err_time2;
`endif

  always #5 clk = ~clk;

  count_checker #(.DEPTH(DEPTH), .STAT_W(16)) dut (
    .clk(clk), .reset(reset), .count(count), .check_en(check_en),
    .locked(locked), .wrap_cnt(wrap_cnt), .err_cnt(err_cnt),
    .err_valid(err_valid), .err_ready(err_ready),
    .err_expected(err_expected), .err_actual(err_actual),
`ifdef COUNT_CHECKER_TIMESTAMP_EN
    .err_time(err_time),
`endif
    .err_ovf(err_ovf)
  );

  count_checker #(.DEPTH(DEPTH), .STAT_W(2)) dut2 (
    .clk(clk), .reset(reset), .count(count), .check_en(check_en),
    .locked(locked2), .wrap_cnt(wrap_cnt2), .err_cnt(err_cnt2),
    .err_valid(err_valid2), .err_ready(err_ready),
    .err_expected(err_expected2), .err_actual(err_actual2),
`ifdef COUNT_CHECKER_TIMESTAMP_EN
    .err_time(err_time2),
`endif
    .err_ovf(err_ovf2)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: "have a reference sample", "locked", "cooling down after a
  // mismatch", plus a record queue with plain size arithmetic.
  typedef struct {
    logic [7:0]  e;
    logic [7:0]  a;
    int unsigned ts;
  } rec_t;

  rec_t        mq[$];
  bit          m_have, m_lock, m_cool, m_ovf;
  int unsigned m_prev, m_err, m_wrap, m_cyc;

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_have = 0; m_lock = 0; m_cool = 0; m_ovf = 0;
    m_prev = 0; m_err = 0; m_wrap = 0; m_cyc = 0;
  endfunction

  function automatic void model_edge(input logic [7:0] c, input bit en, input bit rdy);
    int unsigned nxt;
    bit          push;
    rec_t        r;
    nxt  = (m_prev + 1) % 256;
    push = 0;
    r    = '{e: 8'h00, a: 8'h00, ts: 0};
    if (!en) begin
      m_have = 0; m_lock = 0; m_cool = 0;
    end else if (!m_have) begin
      m_have = 1; m_prev = c;
    end else if (m_cool) begin
      m_cool = 0; m_prev = c;
    end else if (!m_lock) begin
      if (c == nxt) m_lock = 1;
      m_prev = c;
    end else begin
      if (c != nxt) begin
        push = 1; r.e = 8'(nxt); r.a = c; r.ts = m_cyc;
        m_lock = 0; m_cool = 1; m_err++;
      end else if (m_prev == 255 && c == 0) begin
        m_wrap++;
      end
      m_prev = c;
    end
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(r);
      else m_ovf = 1;
    end
    m_cyc++;
  endfunction

  task automatic compare_all();
    check("locked",      locked,     m_lock);
    check("err_cnt",     err_cnt,    sat(m_err, 65535));
    check("wrap_cnt",    wrap_cnt,   sat(m_wrap, 65535));
    check("err_valid",   err_valid,  mq.size() != 0);
    check("err_ovf",     err_ovf,    m_ovf);
    check("err_cnt_w2",  err_cnt2,   sat(m_err, 3));
    check("wrap_cnt_w2", wrap_cnt2,  sat(m_wrap, 3));
    if (mq.size() != 0) begin
      check("err_expected", err_expected, mq[0].e);
      check("err_actual",   err_actual,   mq[0].a);
`ifdef COUNT_CHECKER_TIMESTAMP_EN
      check("err_time",     err_time,     mq[0].ts);
`endif
    end
  endtask

  // Called at posedge+1; inputs change away from the active edge.
  task automatic step(input logic [7:0] c, input bit en, input bit rdy);
    count = c; check_en = en; err_ready = rdy;
    @(posedge clk);
    model_edge(c, en, rdy);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_locked",   locked,       0);
    check("rst_valid",    err_valid,    0);
    check("rst_expected", err_expected, 0);
    check("rst_actual",   err_actual,   0);
    check("rst_ovf",      err_ovf,      0);
    check("rst_err_cnt",  err_cnt,      0);
    check("rst_wrap_cnt", wrap_cnt,     0);
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;
  endtask

  logic [7:0] gc;

  // One error from ARMED: relock, jump by 5, recover to ARMED.
  task automatic err_once(input bit rdy_on_push);
    gc = gc + 8'd1; step(gc, 1, 0);
    gc = gc + 8'd5; step(gc, 1, rdy_on_push);
    gc = gc + 8'd1; step(gc, 1, 0);
  endtask

  task automatic drain(output int unsigned n);
    bit was_valid;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      was_valid = err_valid;
      step(gc, 0, 1);
      if (was_valid) n++;
      if (!err_valid) break;
    end
  endtask

  typedef struct {
    logic [7:0]  c;
    bit          en;
    bit          rdy;
    bit          lk;
    bit          vld;
    logic [7:0]  ee;
    logic [7:0]  ea;
    int unsigned errs;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int unsigned n_xfer;
    bit          seen_valid;

    tbl[0] = '{8'h40, 1, 0, 0, 0, 8'h00, 8'h00, 0};
    tbl[1] = '{8'h41, 1, 0, 1, 0, 8'h00, 8'h00, 0};
    tbl[2] = '{8'h47, 1, 0, 0, 1, 8'h42, 8'h47, 1};
    tbl[3] = '{8'h48, 1, 0, 0, 1, 8'h42, 8'h47, 1};
    tbl[4] = '{8'h49, 1, 0, 1, 1, 8'h42, 8'h47, 1};
    tbl[5] = '{8'h4A, 1, 1, 1, 0, 8'h00, 8'h00, 1};
    tbl[6] = '{8'h4B, 0, 0, 0, 0, 8'h00, 8'h00, 1};
    tbl[7] = '{8'h4D, 1, 0, 0, 0, 8'h00, 8'h00, 1};
    tbl[8] = '{8'h4E, 1, 0, 1, 0, 8'h00, 8'h00, 1};
    tbl[9] = '{8'h4F, 1, 0, 1, 0, 8'h00, 8'h00, 1};

    count = 8'h00; check_en = 1'b0; err_ready = 1'b0; reset = 1'b1;
    model_reset();
    #2;
    do_reset();

    // Directed table: single mismatch, recovery, pop, enable drop and relock.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].c, tbl[i].en, tbl[i].rdy);
      check("tbl_locked", locked,    tbl[i].lk);
      check("tbl_valid",  err_valid, tbl[i].vld);
      check("tbl_errs",   err_cnt,   tbl[i].errs);
      if (tbl[i].vld) begin
        check("tbl_expected", err_expected, tbl[i].ee);
        check("tbl_actual",   err_actual,   tbl[i].ea);
      end
    end

    // Reset mid-run with a record pending: record discarded, relock in 2 cycles.
    step(8'h60, 1, 0);
    check("pre_rst_valid", err_valid, 1);
    do_reset();
    step(8'h10, 1, 0);
    step(8'h11, 1, 0);
    check("relock_after_rst", locked, 1);

    // Clean run from 0 for 300 cycles.
    do_reset();
    seen_valid = 0;
    for (int i = 0; i < 300; i++) begin
      step(8'(i), 1, 0);
      if (i == 1) check("locked_cycle2", locked, 1);
      if (err_valid) seen_valid = 1;
    end
    check("run_wrap_cnt", wrap_cnt, 1);
    check("run_err_cnt",  err_cnt,  0);
    check("run_no_valid", seen_valid, 0);

    // Six errors with err_ready low: overflow, then in-order drain of four.
    do_reset();
    gc = 8'h00;
    step(gc, 1, 0);
    for (int k = 0; k < 5; k++) err_once(0);
    check("sat_w2_5err", err_cnt2, 3);
    err_once(0);
    check("ovf_set",      err_ovf,      1);
    check("ovf_err_cnt",  err_cnt,      6);
    check("ovf_head_exp", err_expected, 8'h02);
    check("ovf_head_act", err_actual,   8'h06);
    drain(n_xfer);
    check("ovf_transfers", n_xfer, 4);

    // Full FIFO, push with a simultaneous pop: nothing dropped.
    do_reset();
    gc = 8'h80;
    step(gc, 1, 0);
    for (int k = 0; k < 4; k++) err_once(0);
    check("full_no_ovf", err_ovf, 0);
    err_once(1);
    check("full_pushpop_ovf", err_ovf, 0);
    check("full_pushpop_err", err_cnt, 5);
    drain(n_xfer);
    check("full_pushpop_occ", n_xfer, 4);

    // Randomized traffic.
    do_reset();
    gc = 8'($urandom);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      if ($urandom_range(0, 9) == 0) gc = 8'($urandom);
      else gc = gc + 8'd1;
      step(gc, $urandom_range(0, 19) != 0, $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
